// File: rtl/glitcbus_master.sv
// GLITCBUS master: serialises 16-bit address and 32-bit data over an 8-bit
// multiplexed address/data bus, with a configurable read turnaround.
module glitcbus_master #(
  parameter int TURNAROUND = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] gb_adr_i,
  input  logic [31:0] gb_dat_i,
  input  logic        gb_wr_i,
  input  logic        gb_rd_i,
  output logic [31:0] gb_dat_o,
  output logic        gb_ack_o,
  output logic        gb_busy_o,
  output logic        GSEL_B,
  output logic        GRDWR_B,
  output logic [7:0]  GAD_o,
  input  logic [7:0]  GAD_i,
  output logic        GAD_oe_o
);

  typedef enum logic [2:0] {IDLE, ADDR0, ADDR1, WDATA, TURN, RDATA, DONE} state_t;

  localparam logic [1:0] TURN_LAST = 2'(TURNAROUND - 1);

  state_t      state, state_n;
  logic [15:0] adr_q, adr_n;
  logic [31:0] wdat_q, wdat_n;
  logic        rd_q, rd_n;
  logic [1:0]  byte_cnt, byte_cnt_n, turn_cnt, turn_cnt_n;
  logic [1:0]  byte_inc;
  logic        gsel_n, grdwr_n, oe_n, ack_n, busy_n;
  logic [7:0]  gad_n;
  logic [31:0] rdat_n;

  assign byte_inc = byte_cnt + 2'd1;

  // All bus pins and handshake outputs are registered from the next-state decode,
  // so they change together with the state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      adr_q     <= '0;
      wdat_q    <= '0;
      rd_q      <= 1'b0;
      byte_cnt  <= '0;
      turn_cnt  <= '0;
      GSEL_B    <= 1'b1;
      GRDWR_B   <= 1'b1;
      GAD_oe_o  <= 1'b0;
      GAD_o     <= '0;
      gb_ack_o  <= 1'b0;
      gb_busy_o <= 1'b0;
      gb_dat_o  <= '0;
    end else begin
      state     <= state_n;
      adr_q     <= adr_n;
      wdat_q    <= wdat_n;
      rd_q      <= rd_n;
      byte_cnt  <= byte_cnt_n;
      turn_cnt  <= turn_cnt_n;
      GSEL_B    <= gsel_n;
      GRDWR_B   <= grdwr_n;
      GAD_oe_o  <= oe_n;
      GAD_o     <= gad_n;
      gb_ack_o  <= ack_n;
      gb_busy_o <= busy_n;
      gb_dat_o  <= rdat_n;
    end
  end

  always_comb begin
    state_n    = state;
    adr_n      = adr_q;
    wdat_n     = wdat_q;
    rd_n       = rd_q;
    byte_cnt_n = byte_cnt;
    turn_cnt_n = turn_cnt;
    gsel_n     = GSEL_B;
    grdwr_n    = GRDWR_B;
    oe_n       = GAD_oe_o;
    gad_n      = GAD_o;
    ack_n      = 1'b0;
    busy_n     = gb_busy_o;
    rdat_n     = gb_dat_o;

    case (state)
      // The edge closing the ack cycle may already start the next transaction,
      // so back-to-back requests see exactly one deselected cycle.
      IDLE, DONE: begin
        state_n = IDLE;
        gsel_n  = 1'b1;
        oe_n    = 1'b0;
        busy_n  = 1'b0;
        if (gb_wr_i || gb_rd_i) begin
          state_n    = ADDR0;
          adr_n      = gb_adr_i;
          wdat_n     = gb_dat_i;
          rd_n       = !gb_wr_i;
          grdwr_n    = !gb_wr_i;
          gsel_n     = 1'b0;
          oe_n       = 1'b1;
          gad_n      = gb_adr_i[7:0];
          busy_n     = 1'b1;
          byte_cnt_n = '0;
          turn_cnt_n = '0;
        end
      end
      ADDR0: begin
        state_n = ADDR1;
        gad_n   = adr_q[15:8];
      end
      ADDR1: begin
        byte_cnt_n = '0;
        turn_cnt_n = '0;
        if (rd_q) begin
          state_n = TURN;
          oe_n    = 1'b0;
        end else begin
          state_n = WDATA;
          gad_n   = wdat_q[7:0];
        end
      end
      WDATA: begin
        if (byte_cnt == 2'd3) begin
          state_n = DONE;
          gsel_n  = 1'b1;
          oe_n    = 1'b0;
          ack_n   = 1'b1;
        end else begin
          byte_cnt_n = byte_inc;
          gad_n      = wdat_q[{byte_inc, 3'b000} +: 8];
        end
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) begin
          state_n    = RDATA;
          byte_cnt_n = '0;
        end else begin
          turn_cnt_n = turn_cnt + 2'd1;
        end
      end
      RDATA: begin
        rdat_n[{byte_cnt, 3'b000} +: 8] = GAD_i;
        if (byte_cnt == 2'd3) begin
          state_n = DONE;
          gsel_n  = 1'b1;
          ack_n   = 1'b1;
        end else begin
          byte_cnt_n = byte_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_glitcbus_master.sv
// Directed bench for glitcbus_master: one instance with TURNAROUND=1, one with 3.
module tb_glitcbus_master;

  logic        clk;
  logic        rst;
  logic [15:0] adr, adr3;
  logic [31:0] dat;
  logic        wr, rd, rd3;
  logic [7:0]  gad_i, gad3_i;

  logic [31:0] dat_o, dat3_o;
  logic        ack, busy, gsel, grdwr, oe;
  logic        ack3, busy3, gsel3, grdwr3, oe3;
  logic [7:0]  gad_o, gad3_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int acks;
  int n;

  logic [7:0] wexp [6] = '{8'h42, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  glitcbus_master #(.TURNAROUND(1)) dut (
    .clk_i(clk), .rst_i(rst), .gb_adr_i(adr), .gb_dat_i(dat),
    .gb_wr_i(wr), .gb_rd_i(rd), .gb_dat_o(dat_o), .gb_ack_o(ack),
    .gb_busy_o(busy), .GSEL_B(gsel), .GRDWR_B(grdwr), .GAD_o(gad_o),
    .GAD_i(gad_i), .GAD_oe_o(oe)
  );

  glitcbus_master #(.TURNAROUND(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .gb_adr_i(adr3), .gb_dat_i(32'h0),
    .gb_wr_i(1'b0), .gb_rd_i(rd3), .gb_dat_o(dat3_o), .gb_ack_o(ack3),
    .gb_busy_o(busy3), .GSEL_B(gsel3), .GRDWR_B(grdwr3), .GAD_o(gad3_o),
    .GAD_i(gad3_i), .GAD_oe_o(oe3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; rd3 = 1'b0;
    adr = '0; adr3 = '0; dat = '0; gad_i = '0; gad3_i = '0;
    #3;
    check_output("rst_gsel", 32'(gsel), 32'd1);
    check_output("rst_grdwr", 32'(grdwr), 32'd1);
    check_output("rst_oe", 32'(oe), 32'd0);
    check_output("rst_gad", 32'(gad_o), 32'h00);
    check_output("rst_ack", 32'(ack), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_dat", dat_o, 32'h0);
    rst = 1'b0;
    tick;

    $display("[TB] write 0x0042 <= 0xDEADBEEF");
    adr = 16'h0042; dat = 32'hDEADBEEF; wr = 1'b1;
    tick;
    wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_output("wr_gad", 32'(gad_o), 32'(wexp[i]));
      check_output("wr_gsel", 32'(gsel), 32'd0);
      check_output("wr_grdwr", 32'(grdwr), 32'd0);
      check_output("wr_oe", 32'(oe), 32'd1);
      tick;
    end
    check_output("wr_ack7", 32'(ack), 32'd1);
    check_output("wr_ack_gsel", 32'(gsel), 32'd1);
    check_output("wr_ack_oe", 32'(oe), 32'd0);
    check_output("wr_ack_busy", 32'(busy), 32'd1);
    tick;
    check_output("wr_ack_clear", 32'(ack), 32'd0);
    check_output("wr_busy_clear", 32'(busy), 32'd0);
    check_output("wr_gad_hold", 32'(gad_o), 32'hDE);
    check_output("wr_dat_untouched", dat_o, 32'h0);

    $display("[TB] read 0x0010, TURNAROUND=1");
    adr = 16'h0010; rd = 1'b1;
    tick;
    rd = 1'b0;
    check_output("rd_grdwr", 32'(grdwr), 32'd1);
    check_output("rd_adr_lo", 32'(gad_o), 32'h10);
    check_output("rd_adr_oe", 32'(oe), 32'd1);
    tick;
    check_output("rd_adr_hi", 32'(gad_o), 32'h00);
    tick;
    check_output("rd_turn_oe", 32'(oe), 32'd0);
    check_output("rd_turn_gsel", 32'(gsel), 32'd0);
    tick;
    check_output("rd_rdata_oe", 32'(oe), 32'd0);
    gad_i = 8'h78;
    tick;
    gad_i = 8'h56;
    tick;
    gad_i = 8'h34;
    tick;
    gad_i = 8'h12;
    check_output("rd_no_early_ack", 32'(ack), 32'd0);
    tick;
    check_output("rd_ack8", 32'(ack), 32'd1);
    check_output("rd_dat", dat_o, 32'h12345678);
    check_output("rd_ack_gsel", 32'(gsel), 32'd1);
    tick;

    $display("[TB] simultaneous write/read plus a mid-transaction pulse");
    adr = 16'h1234; dat = 32'hCAFEF00D; wr = 1'b1; rd = 1'b1;
    tick;
    wr = 1'b0; rd = 1'b0;
    check_output("sim_grdwr", 32'(grdwr), 32'd0);
    tick;
    tick;
    rd = 1'b1;
    tick;
    rd = 1'b0;
    acks = 0;
    for (int i = 4; i <= 16; i++) begin
      if (ack) acks++;
      tick;
    end
    check_output("sim_one_ack", 32'(acks), 32'd1);
    check_output("sim_dat_kept", dat_o, 32'h12345678);

    $display("[TB] back-to-back level reads");
    gad_i = 8'hC3; adr = 16'h00AA; rd = 1'b1;
    tick;
    for (int i = 0; i < 7; i++) tick;
    check_output("b2b_ack1", 32'(ack), 32'd1);
    check_output("b2b_gap_gsel", 32'(gsel), 32'd1);
    check_output("b2b_dat1", dat_o, 32'hC3C3C3C3);
    gad_i = 8'h3C;
    tick;
    rd = 1'b0;
    check_output("b2b_reselect", 32'(gsel), 32'd0);
    check_output("b2b_adr_lo", 32'(gad_o), 32'hAA);
    check_output("b2b_grdwr", 32'(grdwr), 32'd1);
    check_output("b2b_dat_hold", dat_o, 32'hC3C3C3C3);
    for (int i = 0; i < 7; i++) tick;
    check_output("b2b_ack2", 32'(ack), 32'd1);
    check_output("b2b_dat2", dat_o, 32'h3C3C3C3C);
    tick;
    check_output("b2b_idle_gsel", 32'(gsel), 32'd1);
    check_output("b2b_idle_busy", 32'(busy), 32'd0);

    $display("[TB] reset during RDATA byte 2");
    adr = 16'h0055; rd = 1'b1; gad_i = 8'h99;
    tick;
    rd = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    #1 rst = 1'b1;
    #1;
    check_output("rst_mid_gsel", 32'(gsel), 32'd1);
    check_output("rst_mid_oe", 32'(oe), 32'd0);
    check_output("rst_mid_dat", dat_o, 32'h0);
    check_output("rst_mid_busy", 32'(busy), 32'd0);
    check_output("rst_mid_grdwr", 32'(grdwr), 32'd1);
    check_output("rst_mid_gad", 32'(gad_o), 32'h00);
    #1 rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (ack) acks++;
    end
    check_output("rst_mid_no_ack", 32'(acks), 32'd0);
    adr = 16'h0001; dat = 32'h11223344; wr = 1'b1;
    tick;
    wr = 1'b0;
    n = 1;
    while (!ack && n < 12) begin
      tick;
      n++;
    end
    check_output("post_rst_wr_latency", 32'(n), 32'd7);
    check_output("post_rst_dat", dat_o, 32'h0);
    tick;

    $display("[TB] read with TURNAROUND=3");
    adr3 = 16'h0F0F; rd3 = 1'b1;
    tick;
    rd3 = 1'b0;
    check_output("t3_adr_lo", 32'(gad3_o), 32'h0F);
    check_output("t3_grdwr", 32'(grdwr3), 32'd1);
    tick;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_output("t3_turn_oe", 32'(oe3), 32'd0);
      check_output("t3_turn_gsel", 32'(gsel3), 32'd0);
    end
    tick;
    gad3_i = 8'hA1;
    tick;
    gad3_i = 8'hB2;
    tick;
    gad3_i = 8'hC3;
    tick;
    gad3_i = 8'hD4;
    check_output("t3_no_early_ack", 32'(ack3), 32'd0);
    tick;
    check_output("t3_ack10", 32'(ack3), 32'd1);
    check_output("t3_dat", dat3_o, 32'hD4C3B2A1);
    tick;
    check_output("t3_busy_clear", 32'(busy3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
